exec_sequencer: RTL

- Multi-cycle execution and interrupt-entry sequencer for the AVR core.
- Generates the `clock_counter` and `interrupt_stage` codes that the control-select logic decodes into datapath mux selects.
- Stalls fetch/PC while a multi-cycle instruction or an interrupt entry is in progress.
- Arbitrates pending interrupt requests at instruction boundaries and supplies the vector address.

---
 rtl/exec_sequencer_if.sv | 33 +++
 rtl/exec_sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/exec_sequencer_if.sv
// rtl/exec_sequencer_if.sv - decoder/sequencer handshake bundle for the AVR execution sequencer
interface exec_sequencer_if #(
  parameter int NUM_IRQ = 8,
  parameter int VEC_W   = 12
);
  // Instruction stream from the decoder and core status
  logic               instr_valid;
  logic [7:0]         instruction_id;
  logic               branch_taken;
  logic               sreg_i;
  logic [NUM_IRQ-1:0] irq_req;

  // Sequencing codes and control pulses back to the core
  logic [1:0]         clock_counter;
  logic [1:0]         interrupt_stage;
  logic               pc_stall;
  logic [VEC_W-1:0]   irq_vector;
  logic [NUM_IRQ-1:0] irq_ack;
  logic               clear_i;
  logic               set_i;

  // Decoder / core side
  modport master (
    output instr_valid, instruction_id, branch_taken, sreg_i, irq_req,
    input  clock_counter, interrupt_stage, pc_stall, irq_vector, irq_ack, clear_i, set_i
  );

  // Sequencer side
  modport slave (
    input  instr_valid, instruction_id, branch_taken, sreg_i, irq_req,
    output clock_counter, interrupt_stage, pc_stall, irq_vector, irq_ack, clear_i, set_i
  );
endinterface

// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - multi-cycle execution and interrupt-entry sequencer for the AVR core
module exec_sequencer #(
  parameter int NUM_IRQ  = 8,
  parameter int VEC_W    = 12,
  parameter int VEC_BASE = 2
) (
  input  logic            clk,
  input  logic            reset,
  exec_sequencer_if.slave bus
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_INT  = 2'd2;

  // Interrupt entry stage codes, in the order they are walked
  localparam logic [1:0] STG_NONE = 2'd0;
  localparam logic [1:0] STG_PCL  = 2'd2;
  localparam logic [1:0] STG_PCH  = 2'd1;
  localparam logic [1:0] STG_VEC  = 2'd3;

  localparam logic [7:0] ID_RETI = 8'h2E;

  logic [1:0]       state_q;
  logic [1:0]       cnt_q;
  logic [1:0]       stage_q;
  logic [VEC_W-1:0] vec_q;

  logic [1:0]         first_cc;
  logic [1:0]         cc_raw;
  logic               final_cycle;
  logic               is_reti;
  logic               accept;
  logic [IDX_W-1:0]   pick;
  logic [NUM_IRQ-1:0] ack_onehot;
  logic [VEC_W-1:0]   vec_next;

  // First-cycle clock_counter (cycle count minus one) from the instruction id
  always_comb begin
    first_cc = 2'd0;
    case (bus.instruction_id)
      8'h2C:                      first_cc = 2'd2; // RCALL
      8'h2D, 8'h2E:               first_cc = 2'd3; // RET, RETI
      8'h22:                      first_cc = 2'd2; // LPM
      8'h2B, 8'h2A, 8'h19,
      8'h38, 8'h2F:               first_cc = 2'd1; // PUSH, POP, LD, ST, RJMP
      8'h04, 8'h05, 8'h06,
      8'h07, 8'h08:               first_cc = bus.branch_taken ? 2'd1 : 2'd0;
      default:                    first_cc = 2'd0;
    endcase
  end

  // Remaining-cycle code and instruction-boundary interrupt eligibility
  always_comb begin
    cc_raw = 2'd0;
    if (state_q == S_IDLE && bus.instr_valid) begin
      cc_raw = first_cc;
    end else if (state_q == S_EXEC) begin
      cc_raw = cnt_q;
    end
    is_reti     = (bus.instruction_id == ID_RETI);
    final_cycle = (state_q != S_INT) && bus.instr_valid && (cc_raw == 2'd0);
    // RETI's own final cycle never accepts, so one more instruction runs first
    accept      = final_cycle && bus.sreg_i && (|bus.irq_req) && !is_reti;
  end

  // Lowest-index pending request wins
  always_comb begin
    pick = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (bus.irq_req[i]) begin
        pick = IDX_W'(i);
      end
    end
  end

  // Acknowledge pulse and vector address for the winning request
  always_comb begin
    int vec_full;
    ack_onehot       = '0;
    ack_onehot[pick] = accept;
    vec_full         = VEC_BASE + 2 * int'(pick);
    vec_next         = vec_full[VEC_W-1:0];
  end

  // Sequencer state: instruction cycle countdown and interrupt entry walk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      stage_q <= STG_NONE;
      vec_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q <= S_INT;
            stage_q <= STG_PCL;
            vec_q   <= vec_next;
          end else if (bus.instr_valid && first_cc != 2'd0) begin
            state_q <= S_EXEC;
            cnt_q   <= first_cc - 2'd1;
          end
        end
        S_EXEC: begin
          if (accept) begin
            state_q <= S_INT;
            stage_q <= STG_PCL;
            vec_q   <= vec_next;
          end else if (cnt_q == 2'd0) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        S_INT: begin
          case (stage_q)
            STG_PCL: stage_q <= STG_PCH;
            STG_PCH: stage_q <= STG_VEC;
            default: begin
              stage_q <= STG_NONE;
              state_q <= S_IDLE;
            end
          endcase
        end
        default: begin
          state_q <= S_IDLE;
          stage_q <= STG_NONE;
        end
      endcase
    end
  end

  // Outputs; combinational terms are forced low while reset is held
  always_comb begin
    bus.clock_counter   = reset ? 2'd0 : cc_raw;
    bus.interrupt_stage = stage_q;
    bus.pc_stall        = !reset && ((cc_raw != 2'd0) || (stage_q != STG_NONE));
    bus.irq_vector      = vec_q;
    bus.irq_ack         = reset ? '0 : ack_onehot;
    bus.clear_i         = (stage_q == STG_VEC);
    bus.set_i           = !reset && final_cycle && is_reti;
  end

endmodule
